// File: rtl/gf_pkg.sv
// Shared GF(2^m) constants and the reducer state encoding, used by the
// multiplier, reducer and inversion controller.
package gf_pkg;

   localparam int GF_M = 4;
   localparam logic [GF_M:0] GF_POLY = 5'b10011;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } state_e;

endpackage

// File: rtl/gf2m_reduce_seq_if.sv
// Valid/ready handshake bundle between the Karatsuba product source, the
// reducer and the downstream consumer.
interface gf2m_reduce_seq_if
   import gf_pkg::*;
#(
   parameter int M = GF_M
) ();

   logic           in_valid;
   logic           in_ready;
   logic [2*M-2:0] in_data;
   logic           out_valid;
   logic           out_ready;
   logic [M-1:0]   out_data;

   modport master (
      output in_valid,
      output in_data,
      output out_ready,
      input  in_ready,
      input  out_valid,
      input  out_data
   );

   modport slave (
      input  in_valid,
      input  in_data,
      input  out_ready,
      output in_ready,
      output out_valid,
      output out_data
   );

endinterface

// File: rtl/gf2m_reduce_step.sv
// One reduction step: clears bit k of r by XORing in POLY aligned so its
// leading term lands on x^k. Only meaningful for k >= M.
module gf2m_reduce_step
   import gf_pkg::*;
#(
   parameter int M  = GF_M,
   parameter int W  = 2*M-1,
   parameter int KW = $clog2(2*M-1)
) (
   input  logic [W-1:0]  r_i,
   input  logic [KW-1:0] k_i,
   input  logic [M:0]    poly_i,
   output logic [W-1:0]  r_o
);

   logic [W-1:0]  poly_ext_s;
   logic [KW-1:0] shift_s;

   assign poly_ext_s = W'(poly_i);
   assign shift_s    = k_i - KW'(M);

   // Conditional subtract (XOR) of the shifted modulus
   always_comb begin
      r_o = r_i;
      if (r_i[k_i]) begin
         r_o = r_i ^ (poly_ext_s << shift_s);
      end else begin
         r_o = r_i;
      end
   end

endmodule

// File: rtl/gf2m_reduce_seq.sv
// Sequential GF(2^M) reducer: folds a 2M-1 bit carry-less product modulo POLY,
// one degree per cycle, behind a valid/ready handshake.
module gf2m_reduce_seq
   import gf_pkg::*;
#(
   parameter int         M    = GF_M,
   parameter logic [M:0] POLY = GF_POLY
) (
   input logic              clk,
   input logic              rst_n,
   gf2m_reduce_seq_if.slave bus
);

   localparam int W  = 2*M-1;
   localparam int KW = $clog2(2*M-1);
   localparam logic [KW-1:0] K_TOP  = KW'(2*M-2);
   localparam logic [KW-1:0] K_LAST = KW'(M);

   state_e         state_q, state_d;
   logic [W-1:0]   r_q, r_d;
   logic [KW-1:0]  k_q, k_d;
   logic           out_valid_q, out_valid_d;
   logic [M-1:0]   out_data_q, out_data_d;
   logic [W-1:0]   step_r_s;

   gf2m_reduce_step #(
      .M  (M),
      .W  (W),
      .KW (KW)
   ) u_step (
      .r_i    (r_q),
      .k_i    (k_q),
      .poly_i (POLY),
      .r_o    (step_r_s)
   );

   // in_ready stays low during reset so nothing is accepted then dropped
   always_comb begin
      bus.in_ready = 1'b0;
      if (!rst_n) begin
         bus.in_ready = 1'b0;
      end else if (state_q == IDLE) begin
         bus.in_ready = 1'b1;
      end else if (state_q == DONE) begin
         bus.in_ready = bus.out_ready;
      end else begin
         bus.in_ready = 1'b0;
      end
   end

   // Next-state and datapath update
   always_comb begin
      state_d     = state_q;
      r_d         = r_q;
      k_d         = k_q;
      out_valid_d = out_valid_q;
      out_data_d  = out_data_q;
      case (state_q)
         IDLE: begin
            if (bus.in_valid) begin
               r_d     = bus.in_data;
               k_d     = K_TOP;
               state_d = BUSY;
            end else begin
               state_d = IDLE;
            end
         end
         BUSY: begin
            r_d = step_r_s;
            k_d = k_q - KW'(1);
            if (k_q == K_LAST) begin
               state_d     = DONE;
               out_valid_d = 1'b1;
               out_data_d  = step_r_s[M-1:0];
            end else begin
               state_d = BUSY;
            end
         end
         DONE: begin
            if (bus.out_ready) begin
               out_valid_d = 1'b0;
               if (bus.in_valid) begin
                  r_d     = bus.in_data;
                  k_d     = K_TOP;
                  state_d = BUSY;
               end else begin
                  state_d = IDLE;
               end
            end else begin
               state_d = DONE;
            end
         end
         default: begin
            state_d     = IDLE;
            out_valid_d = 1'b0;
         end
      endcase
   end

   // State and output registers, synchronous active-low reset
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         r_q         <= '0;
         k_q         <= '0;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
      end else begin
         state_q     <= state_d;
         r_q         <= r_d;
         k_q         <= k_d;
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
      end
   end

   assign bus.out_valid = out_valid_q;
   assign bus.out_data  = out_data_q;

endmodule

// File: tb/tb_gf2m_reduce_seq.sv
// Directed and streaming bench for the M=4, x^4+x+1 reducer.
module tb_gf2m_reduce_seq;

   logic clk;
   logic rst_n;
   int   checks;
   int   errors;

   gf2m_reduce_seq_if #(.M(4)) bus ();

   gf2m_reduce_seq dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [6:0] prod;
      logic [3:0] exp;
   } vec_t;

   vec_t vecs[9];

   // Reference: x^4=x+1, x^5=x^2+x, x^6=x^3+x^2
   function automatic logic [3:0] ref_mod(input logic [6:0] p);
      logic [3:0] r;
      r = p[3:0];
      if (p[4]) r = r ^ 4'h3;
      if (p[5]) r = r ^ 4'h6;
      if (p[6]) r = r ^ 4'hC;
      return r;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, got, exp);
      end
   endtask

   // Offer d, wait for acceptance, then count cycles until out_valid.
   task automatic do_op(input logic [6:0] d, output logic [3:0] res, output int lat);
      int w;
      bus.in_valid = 1'b1;
      bus.in_data  = d;
      w = 0;
      while (!bus.in_ready && w < 20) begin
         tick();
         w++;
      end
      check("accept_timeout", 32'(w < 20), 32'd1);
      tick();
      bus.in_valid = 1'b0;
      lat = 0;
      while (!bus.out_valid && lat < 20) begin
         tick();
         lat++;
      end
      res = bus.out_data;
   endtask

   initial begin
      logic [3:0] res;
      int         lat;
      logic [6:0] svals[16];
      int         idx, got, cyc, last;
      bit         acc;

      checks = 0;
      errors = 0;
      vecs[0] = '{7'h40, 4'hC};
      vecs[1] = '{7'h7F, 4'h6};
      vecs[2] = '{7'h0A, 4'hA};
      vecs[3] = '{7'h13, 4'h0};
      vecs[4] = '{7'h10, 4'h3};
      vecs[5] = '{7'h20, 4'h6};
      vecs[6] = '{7'h00, 4'h0};
      vecs[7] = '{7'h55, 4'hA};
      vecs[8] = '{7'h2B, 4'hD};

      rst_n         = 1'b0;
      bus.in_valid  = 1'b0;
      bus.in_data   = 7'h00;
      bus.out_ready = 1'b0;
      tick();
      tick();
      check("rst_in_ready", 32'(bus.in_ready), 32'd0);
      check("rst_out_valid", 32'(bus.out_valid), 32'd0);
      check("rst_out_data", 32'(bus.out_data), 32'd0);
      rst_n = 1'b1;
      #1;
      check("idle_in_ready", 32'(bus.in_ready), 32'd1);

      bus.out_ready = 1'b1;
      for (int i = 0; i < 9; i++) begin
         do_op(vecs[i].prod, res, lat);
         check($sformatf("vec%0d_latency", i), 32'(lat), 32'd3);
         check($sformatf("vec%0d_data", i), 32'(res), 32'(vecs[i].exp));
      end
      tick();

      // DONE held with out_ready low while new data waits upstream
      bus.out_ready = 1'b0;
      do_op(7'h40, res, lat);
      check("hold_first_latency", 32'(lat), 32'd3);
      bus.in_valid = 1'b1;
      bus.in_data  = 7'h7F;
      for (int i = 0; i < 5; i++) begin
         check("hold_out_data", 32'(bus.out_data), 32'hC);
         check("hold_out_valid", 32'(bus.out_valid), 32'd1);
         check("hold_in_ready", 32'(bus.in_ready), 32'd0);
         tick();
      end
      bus.out_ready = 1'b1;
      #1;
      check("release_in_ready", 32'(bus.in_ready), 32'd1);
      tick();
      bus.in_valid = 1'b0;
      check("release_out_valid_drop", 32'(bus.out_valid), 32'd0);
      lat = 0;
      while (!bus.out_valid && lat < 20) begin
         tick();
         lat++;
      end
      check("b2b_latency", 32'(lat), 32'd3);
      check("b2b_data", 32'(bus.out_data), 32'h6);
      tick();

      // Streaming: one result every 4 cycles
      for (int i = 0; i < 16; i++) svals[i] = 7'($urandom_range(0, 127));
      idx = 0; got = 0; cyc = 0; last = 0;
      bus.in_valid = 1'b1;
      bus.in_data  = svals[0];
      while (got < 16 && cyc < 300) begin
         if (bus.out_valid) begin
            check($sformatf("stream%0d_data", got), 32'(bus.out_data), 32'(ref_mod(svals[got])));
            if (got > 0) check($sformatf("stream%0d_gap", got), 32'(cyc - last), 32'd4);
            last = cyc;
            got++;
         end
         acc = bus.in_ready && bus.in_valid;
         tick();
         cyc++;
         if (acc) begin
            idx++;
            if (idx < 16) bus.in_data = svals[idx];
            else bus.in_valid = 1'b0;
         end
      end
      check("stream_count", 32'(got), 32'd16);
      bus.in_valid = 1'b0;
      tick();
      tick();

      // Reset in the second BUSY cycle aborts the operation
      bus.in_valid = 1'b1;
      bus.in_data  = 7'h7F;
      check("abort_in_ready", 32'(bus.in_ready), 32'd1);
      tick();
      bus.in_valid = 1'b0;
      tick();
      rst_n = 1'b0;
      tick();
      check("abort_out_valid", 32'(bus.out_valid), 32'd0);
      check("abort_out_data", 32'(bus.out_data), 32'd0);
      check("abort_in_ready_low", 32'(bus.in_ready), 32'd0);
      rst_n = 1'b1;
      tick();
      check("abort_in_ready_after", 32'(bus.in_ready), 32'd1);
      tick();
      tick();
      tick();
      check("abort_no_result", 32'(bus.out_valid), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/gf2m_reduce_seq.md
# gf2m_reduce_seq

Sequential modular-reduction stage that sits directly downstream of the GF(2) polynomial (Karatsuba) multipliers in the Itoh-Tsuji inversion datapath. It accepts an unreduced 2M-1 bit carry-less product and reduces it modulo a fixed irreducible polynomial of degree M, one degree per cycle. It returns the M-bit field element through a valid/ready handshake. The default configuration (M=4, x^4+x+1) consumes the 7-bit output of the 4-bit Karatsuba multiplier directly.

## Interface
- Parameters:
- `M`, 4, field degree; input width 2M-1, output width M; legal M ≥ 2
- `POLY`, 5'b10011, irreducible polynomial, M+1 bits, bit M must be 1 (x^4+x+1)
- Ports:
- `clk`  in  1  sole clock, rising edge
- `rst_n`  in  1  reset, synchronous, active-low
- `in_valid`  in  1  `in_data` holds a product to reduce
- `in_ready`  out  1  stage can accept a product this cycle
- `in_data`  in  2M-1  unreduced product, bit i = coefficient of x^i
- `out_valid`  out  1  `out_data` holds a reduced result
- `out_ready`  in  1  consumer accepts `out_data` this cycle
- `out_data`  out  M  `in_data` mod `POLY`

## Operation
- Clocking and reset:
- One clock (`clk`), synchronous active-low reset `rst_n`, sampled on the rising edge.
- Reset values: state=IDLE, `out_valid`=0, `out_data`=0, work register=0, step counter=0. `in_ready`=0 while `rst_n`=0.
- FSM states:
- IDLE: `in_ready`=1. On `in_valid`: load the work register `r` ← `in_data`, counter k ← 2M-2, go to BUSY.
- BUSY: `in_ready`=0. Each edge: if r[k]=1 then r ← r ^ (POLY << (k-M)). Then k ← k-1. When the step at k=M completes, go to DONE.
- DONE: `out_valid`=1, `out_data`=r[M-1:0], held stable until `out_ready`. `in_ready`=`out_ready`.
  - If `out_ready` and `in_valid`: reload and go to BUSY (back-to-back).
  - If `out_ready` alone: go to IDLE.
- Arithmetic: all addition is XOR. No carries. Bits above M-1 are zero after the final step.
- Boundary conditions:
- An input with bits [2M-2:M] all zero still takes M-1 BUSY cycles. Latency is fixed and never data-dependent.
- `in_data`=`POLY` reduces to 0.
- `in_valid` in BUSY is ignored. The upstream must hold its data; nothing is lost because `in_ready`=0.
- Reset asserted mid-BUSY or in DONE aborts the operation. The result is discarded and the reset values apply on the next edge.
- `out_ready` in IDLE or BUSY has no effect.

## Timing
- Latency: M-1 cycles from the accepting edge to the first cycle with `out_valid`=1 (3 cycles at M=4).
- Throughput:
- With `out_ready` held high, one result every M cycles via the DONE→BUSY reload.
- Otherwise one result every M+1 cycles (DONE→IDLE→BUSY).
- All outputs are registered except `in_ready`, which is combinational from state, `out_ready` and `rst_n`.

## Structure
- Shared package `gf_pkg`:
- `GF_M`=4 and `GF_POLY`=5'b10011 constants, shared with the multiplier and inversion controller.
- State enum {IDLE, BUSY, DONE}.
- Sub-module `gf2m_reduce_step`: combinational. Inputs are r, k and `POLY`; output is r with the conditional shifted-polynomial XOR applied. It is kept separate so the inversion controller can reuse it for a fully unrolled reducer.
- Step counter width: clog2(2M-1).

## Test plan
- Reset then accept 7'h40 (x^6), `out_ready`=1: `out_valid` rises exactly 3 cycles after acceptance, `out_data`=4'hC.
- Accept 7'h7F: `out_data`=4'h6. Accept 7'h0A (already reduced): `out_data`=4'hA with identical 3-cycle latency.
- Accept 7'h13 (=`POLY`): `out_data`=4'h0.
- Hold `out_ready`=0 for 5 cycles in DONE while `in_valid`=1 with new data:
  - `out_data` stays stable and `in_ready`=0.
  - On `out_ready`=1 the new product is accepted the same edge, and the next result follows 3 cycles later.
- Stream 16 random products with `in_valid` and `out_ready` high: one result every 4 cycles, all matching a software carry-less mod-x^4+x+1 reference.
- Assert `rst_n`=0 in the second BUSY cycle: next cycle state is IDLE with `out_valid`=0 and `out_data`=0. `in_ready`=1 the cycle after `rst_n` returns high.
